// File: rtl/video_sync_gen.sv
// Master video timing: prescaled horizontal/line counters, blanking/sync decodes,
// and the 1H-rise-clocked phase chain that produces the delayed 2H/4H references.
module video_sync_gen #(
  parameter int DIV      = 14,
  parameter int H_TOTAL  = 456,
  parameter int V_TOTAL  = 262,
  parameter int H_ACTIVE = 336,
  parameter int HS_START = 373,
  parameter int HS_END   = 404,
  parameter int V_ACTIVE = 240,
  parameter int VS_START = 244,
  parameter int VS_END   = 247
) (
  input  logic       clk100,
  input  logic       rst_b,
  output logic       SC_1H,
  output logic       SC_2H,
  output logic       SC_4H,
  output logic       SC_8H,
  output logic       SC_16H,
  output logic       SC_32H,
  output logic       SC_64H,
  output logic       SC_128H,
  output logic       SC_256H,
  output logic [8:0] SC_V,
  output logic       H_TICK,
  output logic       HBLANK_b,
  output logic       VBLANK_b,
  output logic       HSYNC,
  output logic       VSYNC,
  output logic       CLK_2HDL,
  output logic       CLK_4HDL,
  output logic       CLK_4HDL_b,
  output logic       CLK_4HDD,
  output logic       CLK_4HD3_b
);

  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;

  localparam logic [PW-1:0] P_LAST   = PW'(DIV - 1);
  localparam logic [8:0]    H_LAST   = 9'(H_TOTAL - 1);
  localparam logic [8:0]    V_LAST   = 9'(V_TOTAL - 1);
  localparam logic [8:0]    H_ACT    = 9'(H_ACTIVE);
  localparam logic [8:0]    HS_LO    = 9'(HS_START);
  localparam logic [8:0]    HS_HI    = 9'(HS_END);
  localparam logic [8:0]    V_ACT    = 9'(V_ACTIVE);
  localparam logic [8:0]    VS_LO    = 9'(VS_START);
  localparam logic [8:0]    VS_HI    = 9'(VS_END);

  logic [PW-1:0] p;
  logic [8:0]    h;
  logic [8:0]    v;
  logic [8:0]    h_nxt;
  logic [8:0]    v_nxt;
  logic          step;

  logic h_tick;
  logic hblank_b;
  logic vblank_b;
  logic hsync;
  logic vsync;
  logic clk_2hdl;
  logic clk_4hdl;
  logic clk_4hdl_b;
  logic clk_4hdd;
  logic clk_4hd3_b;

  assign step = (p == P_LAST);

  always_comb begin
    h_nxt = h + 9'd1;
    v_nxt = v;
    if (h == H_LAST) begin
      h_nxt = '0;
      v_nxt = (v == V_LAST) ? '0 : v + 9'd1;
    end
  end

  always_ff @(posedge clk100 or negedge rst_b) begin
    if (!rst_b) begin
      p <= '0;
    end else if (step) begin
      p <= '0;
    end else begin
      p <= p + PW'(1);
    end
  end

  // Decodes are taken from the next H/V so they land in the same cycle as the counters.
  always_ff @(posedge clk100 or negedge rst_b) begin
    if (!rst_b) begin
      h        <= '0;
      v        <= '0;
      h_tick   <= 1'b0;
      hblank_b <= 1'b1;
      vblank_b <= 1'b1;
      hsync    <= 1'b0;
      vsync    <= 1'b0;
    end else begin
      h_tick <= step;
      if (step) begin
        h        <= h_nxt;
        v        <= v_nxt;
        hblank_b <= (h_nxt < H_ACT);
        vblank_b <= (v_nxt < V_ACT);
        hsync    <= (h_nxt >= HS_LO) && (h_nxt <= HS_HI);
        vsync    <= (v_nxt >= VS_LO) && (v_nxt <= VS_HI);
      end
    end
  end

  // Emulates flops clocked by the 1H rising edge: they sample the pre-step values.
  always_ff @(posedge clk100 or negedge rst_b) begin
    if (!rst_b) begin
      clk_2hdl   <= 1'b0;
      clk_4hdl   <= 1'b0;
      clk_4hdl_b <= 1'b1;
      clk_4hdd   <= 1'b0;
      clk_4hd3_b <= 1'b1;
    end else if (step && h_nxt[0]) begin
      clk_2hdl   <= h[1];
      clk_4hdl   <= h[2];
      clk_4hdl_b <= ~h[2];
      clk_4hdd   <= ~clk_4hdl_b;
      clk_4hd3_b <= ~clk_4hdd;
    end
  end

  assign SC_1H      = h[0];
  assign SC_2H      = h[1];
  assign SC_4H      = h[2];
  assign SC_8H      = h[3];
  assign SC_16H     = h[4];
  assign SC_32H     = h[5];
  assign SC_64H     = h[6];
  assign SC_128H    = h[7];
  assign SC_256H    = h[8];
  assign SC_V       = v;
  assign H_TICK     = h_tick;
  assign HBLANK_b   = hblank_b;
  assign VBLANK_b   = vblank_b;
  assign HSYNC      = hsync;
  assign VSYNC      = vsync;
  assign CLK_2HDL   = clk_2hdl;
  assign CLK_4HDL   = clk_4hdl;
  assign CLK_4HDL_b = clk_4hdl_b;
  assign CLK_4HDD   = clk_4hdd;
  assign CLK_4HD3_b = clk_4hd3_b;

endmodule

// File: tb/tb_video_sync_gen.sv
// Scoreboard bench for video_sync_gen: three parameter sets share clock and reset,
// expectations come from closed-form arithmetic on the edge count since reset release.
module tb_video_sync_gen;

  localparam int NCFG = 3;
  localparam int VW   = 28;

  localparam int DIV_A      [NCFG] = '{14, 2, 2};
  localparam int H_TOTAL_A  [NCFG] = '{456, 8, 8};
  localparam int V_TOTAL_A  [NCFG] = '{262, 4, 262};
  localparam int H_ACTIVE_A [NCFG] = '{336, 5, 6};
  localparam int HS_START_A [NCFG] = '{373, 6, 2};
  localparam int HS_END_A   [NCFG] = '{404, 6, 3};
  localparam int V_ACTIVE_A [NCFG] = '{240, 3, 240};
  localparam int VS_START_A [NCFG] = '{244, 1, 244};
  localparam int VS_END_A   [NCFG] = '{247, 2, 247};

  typedef logic [VW-1:0]      vec_t;
  typedef logic [NCFG*VW-1:0] exp_t;

  // {H, V, tick, hblank_b, vblank_b, hsync, vsync, 2hdl, 4hdl, 4hdl_b, 4hdd, 4hd3_b}
  localparam vec_t RESET_VEC = {9'd0, 9'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0,
                                1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

  logic clk100 = 1'b0;
  logic rst_b  = 1'b1;
  int   n      = 0;
  int   tests  = 0;
  int   fails  = 0;
  exp_t exp_q[$];
  vec_t act [NCFG];

  always #5 clk100 = ~clk100;

  for (genvar gi = 0; gi < NCFG; gi++) begin : g_dut
    logic       sc_1h, sc_2h, sc_4h, sc_8h, sc_16h, sc_32h, sc_64h, sc_128h, sc_256h;
    logic [8:0] sc_v;
    logic       h_tick, hblank_b, vblank_b, hsync, vsync;
    logic       clk_2hdl, clk_4hdl, clk_4hdl_b, clk_4hdd, clk_4hd3_b;

    video_sync_gen #(
      .DIV(DIV_A[gi]), .H_TOTAL(H_TOTAL_A[gi]), .V_TOTAL(V_TOTAL_A[gi]),
      .H_ACTIVE(H_ACTIVE_A[gi]), .HS_START(HS_START_A[gi]), .HS_END(HS_END_A[gi]),
      .V_ACTIVE(V_ACTIVE_A[gi]), .VS_START(VS_START_A[gi]), .VS_END(VS_END_A[gi])
    ) u_dut (
      .clk100(clk100), .rst_b(rst_b),
      .SC_1H(sc_1h), .SC_2H(sc_2h), .SC_4H(sc_4h), .SC_8H(sc_8h), .SC_16H(sc_16h),
      .SC_32H(sc_32h), .SC_64H(sc_64h), .SC_128H(sc_128h), .SC_256H(sc_256h),
      .SC_V(sc_v), .H_TICK(h_tick), .HBLANK_b(hblank_b), .VBLANK_b(vblank_b),
      .HSYNC(hsync), .VSYNC(vsync), .CLK_2HDL(clk_2hdl), .CLK_4HDL(clk_4hdl),
      .CLK_4HDL_b(clk_4hdl_b), .CLK_4HDD(clk_4hdd), .CLK_4HD3_b(clk_4hd3_b)
    );

    assign act[gi] = {sc_256h, sc_128h, sc_64h, sc_32h, sc_16h, sc_8h, sc_4h, sc_2h, sc_1h,
                      sc_v, h_tick, hblank_b, vblank_b, hsync, vsync,
                      clk_2hdl, clk_4hdl, clk_4hdl_b, clk_4hdd, clk_4hd3_b};
  end

  // H value after k steps since reset.
  function automatic int h_at(int c, int k);
    return k % H_TOTAL_A[c];
  endfunction

  // Expected outputs after cnt rising edges with rst_b high. All configs use an even
  // H_TOTAL, so H is odd exactly on odd step counts and 1H rise r happens at step 2r-1.
  function automatic vec_t model(int c, int cnt);
    int   s, hc, vc, r, hv;
    logic tick, hb, vb, hs, vs, c2, c4, c4b, cdd, c3b;
    s    = cnt / DIV_A[c];
    hc   = h_at(c, s);
    vc   = (s / H_TOTAL_A[c]) % V_TOTAL_A[c];
    tick = (cnt > 0) && (cnt % DIV_A[c] == 0);
    hb   = hc < H_ACTIVE_A[c];
    vb   = vc < V_ACTIVE_A[c];
    hs   = (hc >= HS_START_A[c]) && (hc <= HS_END_A[c]);
    vs   = (vc >= VS_START_A[c]) && (vc <= VS_END_A[c]);
    r    = (s + 1) / 2;
    c2 = 1'b0; c4 = 1'b0; c4b = 1'b1; cdd = 1'b0; c3b = 1'b1;
    if (r >= 1) begin
      hv  = h_at(c, 2 * r - 2);
      c2  = hv[1];
      c4  = hv[2];
      c4b = ~hv[2];
    end
    if (r >= 2) begin
      hv  = h_at(c, 2 * r - 4);
      cdd = hv[2];
    end
    if (r >= 3) begin
      hv  = h_at(c, 2 * r - 6);
      c3b = ~hv[2];
    end
    return {9'(hc), 9'(vc), tick, hb, vb, hs, vs, c2, c4, c4b, cdd, c3b};
  endfunction

  task automatic push_exp();
    exp_t e;
    for (int c = 0; c < NCFG; c++)
      e[c*VW +: VW] = rst_b ? model(c, n) : RESET_VEC;
    exp_q.push_back(e);
  endtask

  // act_code: 0 = run, 1 = assert reset mid-cycle, 2 = release reset mid-cycle
  task automatic cycle(input int act_code);
    @(posedge clk100);
    if (rst_b) n++;
    #2;
    if (act_code == 1) begin
      rst_b = 1'b0;
      n = 0;
    end else if (act_code == 2) begin
      rst_b = 1'b1;
      n = 0;
    end
    push_exp();
  endtask

  task automatic check(input int c, input string name, input vec_t a, input vec_t x);
    tests++;
    if (a !== x) begin
      fails++;
      $display("FAIL cfg%0d %s t=%0t actual=%h required=%h", c, name, $time, a, x);
    end
  endtask

  always @(negedge clk100) begin
    exp_t e;
    vec_t x;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      for (int c = 0; c < NCFG; c++) begin
        x = e[c*VW +: VW];
        check(c, "counters", vec_t'(act[c][27:9]), vec_t'(x[27:9]));
        check(c, "decodes",  vec_t'(act[c][8:5]),  vec_t'(x[8:5]));
        check(c, "phase",    vec_t'(act[c][4:0]),  vec_t'(x[4:0]));
      end
    end
  end

  initial begin
    #1 rst_b = 1'b0;
    repeat (20) cycle(0);
    cycle(2);
    repeat (456 * 14 + 300) cycle(0);
    cycle(1);
    repeat ($urandom_range(1, 5)) cycle(0);
    cycle(2);
    repeat ($urandom_range(2000, 5000)) cycle(0);
    cycle(1);
    repeat (3) cycle(0);
    cycle(2);
    repeat (4300) cycle(0);
    @(negedge clk100);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
